// File: rtl/ripple_carry_adder_8b.sv
// Registered WIDTH-bit ripple-carry adder: {cout,sum} <= a + b + cin one clock after
// the operands, built from a chain of one-bit full adders.

module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p_s;

    // Propagate term is shared between the sum and the carry.
    assign p_s = a_i ^ b_i;
    assign s_o = p_s ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p_s);

endmodule

module ripple_carry_adder_8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry_s[0] = cin;

    // Carry ripples strictly LSB to MSB through one full adder per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rca_full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (carry_s[i]),
            .s_o (sum_d[i]),
            .c_o (carry_s[i+1])
        );
    end

    assign cout_d = carry_s[WIDTH];

    // Output register; reset clears immediately and masks any unknown operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_ripple_carry_adder_8b.sv
// Scoreboarded bench for ripple_carry_adder_8b: expected {cout,sum} from plain
// integer addition is queued at issue time and popped by an independent monitor.

module tb_ripple_carry_adder_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    logic [8:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    ripple_carry_adder_8b #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got {cout,sum}=%h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: unsigned sum in 9 bits, so carry-out is simply bit 8.
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned total;
        total = 32'(x) + 32'(y) + 32'(c);
        return total[8:0];
    endfunction

    task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a   = ta;
        b   = tb;
        cin = tc;
        exp_q.push_back(ref_add(ta, tb, tc));
    endtask

    // Monitor: every captured edge outside reset yields one result to compare.
    always @(posedge clk) begin
        if (mon_en && rst) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got {cout,sum}=%h with no expected entry at %0t",
                         {cout, sum}, $time);
            end else begin
                check("scoreboard", {cout, sum}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        a   = 8'h5A;
        b   = 8'h33;
        cin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", {cout, sum}, 9'h000);
        end

        @(negedge clk);
        rst = 1'b1;
        check("release_no_capture_yet", {cout, sum}, 9'h000);
        @(posedge clk);
        #1;
        check("first_capture", {cout, sum}, 9'h08E);

        mon_en = 1'b1;
        issue(8'd15,  8'd10,  1'b0);
        issue(8'd200, 8'd55,  1'b1);
        issue(8'h7F,  8'h80,  1'b1);
        issue(8'hFF,  8'h01,  1'b0);
        issue(8'hFF,  8'hFF,  1'b0);
        issue(8'h00,  8'h00,  1'b0);
        issue(8'hFF,  8'hFF,  1'b1);
        for (int i = 0; i < 5000; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom));
        end
        issue(8'hAA, 8'h11, 1'b0);

        @(negedge clk);
        mon_en = 1'b0;
        check("sb_drain", 9'(exp_q.size()), 9'd0);
        check("hold_value", {cout, sum}, 9'h0BB);

        // Reset mid-cycle with a pending operation: clears before the next edge.
        a   = 8'hFF;
        b   = 8'h01;
        cin = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", {cout, sum}, 9'h000);

        a   = 'x;
        b   = 'x;
        cin = 1'bx;
        @(posedge clk);
        #1;
        check("reset_x_inputs", {cout, sum}, 9'h000);

        @(negedge clk);
        a   = 8'd3;
        b   = 8'd4;
        cin = 1'b1;
        rst = 1'b1;
        #1;
        check("pending_discarded", {cout, sum}, 9'h000);
        @(posedge clk);
        #1;
        check("post_release_capture", {cout, sum}, ref_add(8'd3, 8'd4, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
